// File: rtl/dds_cfg_pkg.sv
// rtl/dds_cfg_pkg.sv - shared types, codes, reset values and lookup tables
// The lookup functions return the reset value for an out-of-range index; callers range-check first.
package dds_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_CHECK,
        ST_WAIT_SYNC,
        ST_COMMIT
    } state_t;

    localparam logic [3:0] HDR_MARK   = 4'hA;
    localparam logic [2:0] SEL_CLR    = 3'd0;
    localparam logic [2:0] SEL_COE_A  = 3'd1;
    localparam logic [2:0] SEL_DELAY  = 3'd2;
    localparam logic [2:0] SEL_FREQ   = 3'd3;
    localparam logic [2:0] SEL_PHASE  = 3'd4;
    localparam logic [2:0] SEL_DAC1   = 3'd5;
    localparam logic [2:0] SEL_DAC2   = 3'd6;
    localparam logic [2:0] SEL_COMMIT = 3'd7;

    localparam logic [3:0] COE_A_MAX_IDX = 4'd6;
    localparam logic [3:0] DELAY_MAX_IDX = 4'd5;
    localparam logic [3:0] FREQ_MAX_IDX  = 4'd10;
    localparam logic [3:0] PHASE_MAX_IDX = 4'd6;

    localparam logic [7:0]  RST_COE_A = 8'd39;
    localparam logic [2:0]  RST_DELAY = 3'd0;
    localparam logic [31:0] RST_FREQ  = 32'd1030792151;
    localparam logic [7:0]  RST_PHASE = 8'd0;
    localparam logic [7:0]  RST_DAC1  = 8'd128;
    localparam logic [7:0]  RST_DAC2  = 8'd128;

    typedef struct packed {
        logic [7:0]  coe_a;
        logic [2:0]  delay;
        logic [31:0] freq;
        logic [7:0]  phase;
        logic [7:0]  dac1;
        logic [7:0]  dac2;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{coe_a: RST_COE_A, delay: RST_DELAY, freq: RST_FREQ,
                                   phase: RST_PHASE, dac1: RST_DAC1, dac2: RST_DAC2};

    function automatic logic [7:0] coe_a_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    coe_a_lut = 8'd39;
            4'd1:    coe_a_lut = 8'd51;
            4'd2:    coe_a_lut = 8'd64;
            4'd3:    coe_a_lut = 8'd77;
            4'd4:    coe_a_lut = 8'd90;
            4'd5:    coe_a_lut = 8'd103;
            4'd6:    coe_a_lut = 8'd115;
            default: coe_a_lut = RST_COE_A;
        endcase
    endfunction

    // round(2^32 * (30 + idx) / 125): 30..40 MHz carrier at 125 MHz clock
    function automatic logic [31:0] freq_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    freq_lut = 32'd1030792151;
            4'd1:    freq_lut = 32'd1065151889;
            4'd2:    freq_lut = 32'd1099511628;
            4'd3:    freq_lut = 32'd1133871366;
            4'd4:    freq_lut = 32'd1168231105;
            4'd5:    freq_lut = 32'd1202590843;
            4'd6:    freq_lut = 32'd1236950581;
            4'd7:    freq_lut = 32'd1271310320;
            4'd8:    freq_lut = 32'd1305670058;
            4'd9:    freq_lut = 32'd1340029796;
            4'd10:   freq_lut = 32'd1374389535;
            default: freq_lut = RST_FREQ;
        endcase
    endfunction

    function automatic logic [7:0] phase_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    phase_lut = 8'd0;
            4'd1:    phase_lut = 8'd21;
            4'd2:    phase_lut = 8'd43;
            4'd3:    phase_lut = 8'd64;
            4'd4:    phase_lut = 8'd85;
            4'd5:    phase_lut = 8'd107;
            4'd6:    phase_lut = 8'd128;
            default: phase_lut = RST_PHASE;
        endcase
    endfunction

endpackage

// File: rtl/mcu_byte_sync.sv
// rtl/mcu_byte_sync.sv - MCU write strobe synchroniser and byte capture
// Two-flop synchroniser on the strobe, rising-edge detect, one-cycle byte valid.
module mcu_byte_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_byte_vld,
    output logic [7:0] o_byte
);

    logic [2:0] r_wr_sync;
    logic       r_byte_vld;
    logic [7:0] r_byte;
    logic       w_rise;

    assign w_rise = r_wr_sync[1] & ~r_wr_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_sync  <= 3'b000;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'h00;
        end else begin
            r_wr_sync  <= {r_wr_sync[1:0], i_wr};
            r_byte_vld <= w_rise;
            if (w_rise) begin
                r_byte <= i_data;
            end
        end
    end

    assign o_byte_vld = r_byte_vld;
    assign o_byte     = r_byte;

endmodule

// File: rtl/dds_cfg_sequencer.sv
// rtl/dds_cfg_sequencer.sv - MCU command sequencer with frame-sync aligned atomic commit
// Optional FRAME_CHK_EN adds a byte0^byte1 check byte to every frame (header repeated for commit).
module dds_cfg_sequencer
    import dds_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYC      = 1000,
    parameter int SYNC_TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mcu_wr,
    input  logic [7:0]  i_mcu_data,
    input  logic        i_frame_sync,
    output logic [7:0]  o_coe_a,
    output logic [2:0]  o_delay,
    output logic [31:0] o_freq_word,
    output logic [7:0]  o_phase_word,
    output logic [7:0]  o_dac1_coe,
    output logic [7:0]  o_dac2_coe,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_commit_done
);

    logic        w_byte_vld;
    logic [7:0]  w_byte;
    logic [3:0]  w_idx;
    logic        w_hi_zero;
    logic        w_range_ok;
    cfg_t        w_shadow_nxt;
    logic        w_byte_to;
    logic        w_sync_to;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_sel;
    logic [7:0]  r_data;
    cfg_t        r_shadow;
    cfg_t        r_active;
    logic        r_busy;
    logic        r_err;
    logic        r_commit_done;
`ifdef FRAME_CHK_EN
    logic [7:0]  r_chk_exp;
`endif

    mcu_byte_sync u_byte_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr       (i_mcu_wr),
        .i_data     (i_mcu_data),
        .o_byte_vld (w_byte_vld),
        .o_byte     (w_byte)
    );

    assign w_idx     = r_data[3:0];
    assign w_hi_zero = (r_data[7:4] == 4'd0);
    assign w_byte_to = (32'(r_cnt) >= 32'(TIMEOUT_CYC - 1));
    assign w_sync_to = (32'(r_cnt) >= 32'(SYNC_TIMEOUT_CYC - 1));

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_range_ok   = 1'b1;
        case (r_sel)
            SEL_COE_A: begin
                if (w_hi_zero && w_idx <= COE_A_MAX_IDX) w_shadow_nxt.coe_a = coe_a_lut(w_idx);
                else                                      w_range_ok = 1'b0;
            end
            SEL_DELAY: begin
                if (w_hi_zero && w_idx <= DELAY_MAX_IDX) w_shadow_nxt.delay = w_idx[2:0];
                else                                      w_range_ok = 1'b0;
            end
            SEL_FREQ: begin
                if (w_hi_zero && w_idx <= FREQ_MAX_IDX) w_shadow_nxt.freq = freq_lut(w_idx);
                else                                     w_range_ok = 1'b0;
            end
            SEL_PHASE: begin
                if (w_hi_zero && w_idx <= PHASE_MAX_IDX) w_shadow_nxt.phase = phase_lut(w_idx);
                else                                      w_range_ok = 1'b0;
            end
            SEL_DAC1: w_shadow_nxt.dac1 = r_data;
            SEL_DAC2: w_shadow_nxt.dac2 = r_data;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 16'd0;
            r_sel         <= SEL_CLR;
            r_data        <= 8'h00;
            r_shadow      <= CFG_RESET;
            r_active      <= CFG_RESET;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_commit_done <= 1'b0;
`ifdef FRAME_CHK_EN
            r_chk_exp     <= 8'h00;
`endif
        end else begin
            r_commit_done <= 1'b0;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_vld) begin
                        if (w_byte[7:4] != HDR_MARK) begin
                            r_err <= 1'b1;
                        end else begin
                            r_sel  <= w_byte[2:0];
                            r_data <= 8'h00;
                            r_cnt  <= 16'd0;
                            r_busy <= 1'b1;
`ifdef FRAME_CHK_EN
                            r_chk_exp <= w_byte;
                            r_state   <= (w_byte[2:0] == SEL_COMMIT) ? ST_GET_CHK : ST_GET_DATA;
`else
                            r_state   <= (w_byte[2:0] == SEL_COMMIT) ? ST_WAIT_SYNC : ST_GET_DATA;
`endif
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (w_byte_vld) begin
                        r_data <= w_byte;
                        r_cnt  <= 16'd0;
`ifdef FRAME_CHK_EN
                        r_chk_exp <= r_chk_exp ^ w_byte;
                        r_state   <= ST_GET_CHK;
`else
                        r_state   <= ST_CHECK;
`endif
                    end else if (w_byte_to) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
`ifdef FRAME_CHK_EN
                ST_GET_CHK: begin
                    if (w_byte_vld) begin
                        r_cnt <= 16'd0;
                        if (w_byte != r_chk_exp) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= (r_sel == SEL_COMMIT) ? ST_WAIT_SYNC : ST_CHECK;
                        end
                    end else if (w_byte_to) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                ST_CHECK: begin
                    if (r_sel == SEL_CLR) begin
                        r_err <= 1'b0;
                    end else if (!w_range_ok) begin
                        r_err <= 1'b1;
                    end
                    if (w_range_ok) begin
                        r_shadow <= w_shadow_nxt;
                    end
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
                ST_WAIT_SYNC: begin
                    if (w_byte_vld) begin
                        r_err <= 1'b1;
                    end
                    if (i_frame_sync || w_sync_to) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (w_byte_vld) begin
                        r_err <= 1'b1;
                    end
                    r_active      <= r_shadow;
                    r_commit_done <= 1'b1;
                    r_busy        <= 1'b0;
                    r_cnt         <= 16'd0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_coe_a       = r_active.coe_a;
    assign o_delay       = r_active.delay;
    assign o_freq_word   = r_active.freq;
    assign o_phase_word  = r_active.phase;
    assign o_dac1_coe    = r_active.dac1;
    assign o_dac2_coe    = r_active.dac2;
    assign o_busy        = r_busy;
    assign o_err         = r_err;
    assign o_commit_done = r_commit_done;

endmodule
